// File: rtl/gearbox_tx_param.sv
// TX gearbox: packs IN_WIDTH-bit scrambled blocks into OUT_WIDTH-bit line words.
// Line side is paced by out_en; the input side is throttled through in_ready.
module gearbox_tx_param #(
   parameter int IN_WIDTH        = 66,
   parameter int OUT_WIDTH       = 64,
   parameter int MSB_FIRST       = 0,
   parameter int UFLOW_CNT_WIDTH = 16
) (
   input  logic                                       clock,
   input  logic                                       reset_n,
   input  logic                                       clear,
   input  logic [IN_WIDTH-1:0]                        in_data,
   input  logic                                       in_valid,
   output logic                                       in_ready,
   input  logic                                       out_en,
   output logic [OUT_WIDTH-1:0]                       out_data,
   output logic                                       out_valid,
   output logic [UFLOW_CNT_WIDTH-1:0]                 uflow_count,
   output logic [$clog2(IN_WIDTH+OUT_WIDTH+1)-1:0]    fill_level
);

   localparam int CAP   = IN_WIDTH + OUT_WIDTH;
   localparam int CNT_W = $clog2(CAP + 1);

   logic [CAP-1:0]             buf_reg, buf_next, buf_shifted, blk_placed;
   logic [CNT_W-1:0]           count_reg, count_next, base;
   logic [IN_WIDTH-1:0]        blk;
   logic [OUT_WIDTH-1:0]       out_data_reg;
   logic                       out_valid_reg;
   logic [UFLOW_CNT_WIDTH-1:0] uflow_reg;
   logic                       emit, accept, ready_int;

   // Optional bit reversal so the chosen end of the block goes out first.
   generate
      for (genvar gi = 0; gi < IN_WIDTH; gi++) begin : g_order
         if (MSB_FIRST != 0) begin : g_rev
            assign blk[gi] = in_data[IN_WIDTH-1-gi];
         end else begin : g_fwd
            assign blk[gi] = in_data[gi];
         end
      end
   endgenerate

   always_comb begin
      emit        = out_en && (count_reg >= CNT_W'(OUT_WIDTH));
      base        = emit ? (count_reg - CNT_W'(OUT_WIDTH)) : count_reg;
      ready_int   = reset_n && !clear && (base <= CNT_W'(OUT_WIDTH));
      accept      = in_valid && ready_int;
      buf_shifted = emit ? (buf_reg >> OUT_WIDTH) : buf_reg;
      // Bits above count are always zero, so a plain OR places the new block.
      blk_placed  = {{OUT_WIDTH{1'b0}}, blk} << base;
      buf_next    = accept ? (buf_shifted | blk_placed) : buf_shifted;
      count_next  = accept ? (base + CNT_W'(IN_WIDTH)) : base;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         buf_reg       <= '0;
         count_reg     <= '0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         uflow_reg     <= '0;
      end else if (clear) begin
         buf_reg       <= '0;
         count_reg     <= '0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         uflow_reg     <= '0;
      end else begin
         buf_reg   <= buf_next;
         count_reg <= count_next;
         if (emit) begin
            out_data_reg  <= buf_reg[OUT_WIDTH-1:0];
            out_valid_reg <= 1'b1;
         end else if (out_en) begin
            // Never emit a partial word: underflow sends zeros and is counted.
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            if (uflow_reg != '1) begin
               uflow_reg <= uflow_reg + UFLOW_CNT_WIDTH'(1);
            end
         end
      end
   end

   assign in_ready    = ready_int;
   assign out_data    = out_data_reg;
   assign out_valid   = out_valid_reg;
   assign uflow_count = uflow_reg;
   assign fill_level  = count_reg;

endmodule

// File: tb/tb_gearbox_tx_param.sv
// Bench for gearbox_tx_param: a bit-stream model feeds an expected-word queue
// that a monitor drains on every line-side out_en cycle; directed checks on top.
module tb_gearbox_tx_param;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        clear = 1'b0;
   logic [65:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        out_en = 1'b0;

   logic        in_ready, out_valid;
   logic [63:0] out_data;
   logic [15:0] uflow_count;
   logic [7:0]  fill_level;

   logic        b_in_ready, b_out_valid;
   logic [63:0] b_out_data;
   logic [2:0]  b_uflow_count;
   logic [7:0]  b_fill_level;

   int          checks = 0;
   int          failures = 0;
   logic [64:0] exp_q[$];
   bit          mq[$];

   always #5 clock = ~clock;

   gearbox_tx_param dut_a (
      .clock(clock), .reset_n(reset_n), .clear(clear),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_en(out_en), .out_data(out_data), .out_valid(out_valid),
      .uflow_count(uflow_count), .fill_level(fill_level)
   );

   gearbox_tx_param #(.MSB_FIRST(1), .UFLOW_CNT_WIDTH(3)) dut_b (
      .clock(clock), .reset_n(reset_n), .clear(clear),
      .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
      .out_en(out_en), .out_data(b_out_data), .out_valid(b_out_valid),
      .uflow_count(b_uflow_count), .fill_level(b_fill_level)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every line-side word slot pops one expected {valid, data}.
   always @(posedge clock) begin : mon
      logic        en_s;
      logic [64:0] e;
      en_s = out_en && !clear && reset_n;
      #1;
      if (en_s) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty actual=%0h required=none", {out_valid, out_data});
         end else begin
            e = exp_q.pop_front();
            chk("sb_word", {63'h0, out_valid, out_data}, {63'h0, e});
         end
      end
   end

   // One clock of stimulus; model the bit stream and queue the expected word.
   task automatic step(input logic v, input logic [65:0] d, input logic en, output logic dut_acc);
      bit          emit;
      int          base;
      logic        exp_rdy;
      logic [63:0] w;
      chk("fill_level", 128'(fill_level), 128'(mq.size()));
      in_valid = v;
      in_data  = d;
      out_en   = en;
      #1;
      emit    = en && (mq.size() >= 64);
      base    = mq.size() - (emit ? 64 : 0);
      exp_rdy = (base <= 64);
      chk("in_ready", 128'(in_ready), 128'(exp_rdy));
      chk("b_in_ready", 128'(b_in_ready), 128'(exp_rdy));
      dut_acc = v && in_ready;
      if (en) begin
         if (emit) begin
            for (int i = 0; i < 64; i++) w[i] = mq.pop_front();
            exp_q.push_back({1'b1, w});
         end else begin
            exp_q.push_back({1'b0, 64'h0});
         end
      end
      if (v && exp_rdy) begin
         for (int i = 0; i < 66; i++) mq.push_back(d[i]);
      end
      @(negedge clock);
   endtask

   task automatic do_clear();
      clear    = 1'b1;
      in_valid = 1'b0;
      out_en   = 1'b0;
      @(negedge clock);
      clear = 1'b0;
      mq.delete();
   endtask

   initial begin : stim
      logic        acc;
      logic [63:0] held;
      int          lows, first_low, accs, blk_n, nvalid, max_fill;
      logic [65:0] ones;
      ones = '1;

      // Reset state
      repeat (2) @(negedge clock);
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      chk("rst_b_in_ready", 128'(b_in_ready), 128'(0));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_data", 128'(out_data), 128'(0));
      chk("rst_uflow", 128'(uflow_count), 128'(0));
      chk("rst_fill", 128'(fill_level), 128'(0));
      reset_n = 1'b1;

      // Steady state 66/64
      lows = 0; first_low = -1; blk_n = 0;
      for (int c = 0; c < 100; c++) begin
         step(1'b1, {64'(blk_n), 2'b01}, 1'b1, acc);
         if (acc) blk_n++;
         else begin
            lows++;
            if (first_low < 0) first_low = c;
         end
         if (c == 0) begin
            chk("ss_c0_valid", 128'(out_valid), 128'(0));
            chk("ss_c0_uflow", 128'(uflow_count), 128'(1));
         end
      end
      chk("ss_first_low", 128'(first_low), 128'(33));
      chk("ss_low_count", 128'(lows), 128'(3));

      // Reset mid-stream
      #2 reset_n = 1'b0;
      #1;
      chk("mr_fill", 128'(fill_level), 128'(0));
      chk("mr_valid", 128'(out_valid), 128'(0));
      chk("mr_data", 128'(out_data), 128'(0));
      chk("mr_in_ready", 128'(in_ready), 128'(0));
      mq.delete();
      @(negedge clock);
      reset_n = 1'b1;

      // Alignment after reset: zeros+header 01, then all ones
      step(1'b1, 66'h1, 1'b1, acc);
      chk("al_uflow", 128'(uflow_count), 128'(1));
      step(1'b1, ones, 1'b1, acc);
      chk("al_word0", 128'(out_data), 128'(64'h0000_0000_0000_0001));
      step(1'b0, 66'h0, 1'b1, acc);
      chk("al_word1", 128'(out_data), 128'(64'hFFFF_FFFF_FFFF_FFFC));
      step(1'b0, 66'h0, 1'b0, acc);
      chk("al_left", 128'(fill_level), 128'(4));

      // Clear with 68 bits buffered
      do_clear();
      step(1'b1, 66'h1, 1'b1, acc);
      step(1'b1, ones, 1'b1, acc);
      chk("cl_fill68", 128'(fill_level), 128'(68));
      clear = 1'b1; in_valid = 1'b1; out_en = 1'b1;
      #1;
      chk("cl_in_ready", 128'(in_ready), 128'(0));
      @(negedge clock);
      clear = 1'b0;
      mq.delete();
      chk("cl_fill", 128'(fill_level), 128'(0));
      chk("cl_valid", 128'(out_valid), 128'(0));
      chk("cl_data", 128'(out_data), 128'(0));
      chk("cl_uflow", 128'(uflow_count), 128'(0));
      step(1'b1, 66'h1_2345_6789_ABCD_EF01, 1'b1, acc);
      step(1'b0, 66'h0, 1'b1, acc);
      chk("cl_realign", 128'(out_data), 128'(64'h2345_6789_ABCD_EF01));

      // out_en toggling
      do_clear();
      accs = 0; max_fill = 0;
      for (int p = 0; p < 68; p++) begin
         step(1'b1, {64'(blk_n), 2'b10}, 1'b1, acc);
         if (acc) blk_n++;
         if (acc && p >= 1 && p <= 33) accs++;
         held = out_data;
         if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
         step(1'b1, {64'(blk_n), 2'b10}, 1'b0, acc);
         if (acc) blk_n++;
         if (p < 4) begin
            chk("tg_hold", 128'(out_data), 128'(held));
            chk("tg_no_acc", 128'(acc), 128'(0));
         end
      end
      chk("tg_accepts", 128'(accs), 128'(32));
      chk("tg_max_fill", 128'(max_fill <= 130), 128'(1));

      // Five blocks then starve; underflow count and saturation
      do_clear();
      nvalid = 0;
      for (int c = 0; c < 11; c++) begin
         step(c < 5, {64'(blk_n), 2'b01}, 1'b1, acc);
         if (acc) blk_n++;
         if (out_valid) nvalid++;
      end
      chk("uf_words", 128'(nvalid), 128'(5));
      chk("uf_valid_end", 128'(out_valid), 128'(0));
      chk("uf_fill", 128'(fill_level), 128'(10));
      chk("uf_count", 128'(uflow_count), 128'(6));
      chk("uf_b_count", 128'(b_uflow_count), 128'(6));
      repeat (10) step(1'b0, 66'h0, 1'b1, acc);
      chk("uf_count16", 128'(uflow_count), 128'(16));
      chk("uf_b_sat", 128'(b_uflow_count), 128'(7));
      repeat (5) step(1'b0, 66'h0, 1'b1, acc);
      chk("uf_b_sat_hold", 128'(b_uflow_count), 128'(7));

      // MSB_FIRST instance: single bit 0 lands at position 65
      do_clear();
      step(1'b1, 66'h1, 1'b1, acc);
      step(1'b1, 66'h0, 1'b1, acc);
      chk("msb_word0", 128'(b_out_data), 128'(0));
      chk("msb_valid0", 128'(b_out_valid), 128'(1));
      step(1'b0, 66'h0, 1'b1, acc);
      chk("msb_word1", 128'(b_out_data), 128'(64'h2));

      out_en = 1'b0; in_valid = 1'b0;
      repeat (3) @(negedge clock);
      chk("sb_drain", 128'(exp_q.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gearbox_tx_param.md
Name: gearbox_tx_param

Overview:
- Parametrised TX gearbox for the 64b66b PCS transmit chain.
- Sits between the scrambler output and the serializer interface; converts IN_WIDTH-bit blocks (default 66b) into OUT_WIDTH-bit line words (default 64b).
- Runs in a single clock domain. A per-cycle out_en strobe paces the line side, and a valid/ready handshake applies backpressure to the scrambler, replacing the gated /66 clock.
- Successor to fixed 66->64 gearing: any IN_WIDTH >= OUT_WIDTH ratio, selectable bit order, underflow statistics, synchronous flush.

Parameters:
- IN_WIDTH, 66, input block width (must be >= OUT_WIDTH).
- OUT_WIDTH, 64, output line-word width.
- MSB_FIRST, 0, 0 = input bit 0 (sync header bit 0) is transmitted first; 1 = each input block is bit-reversed on entry.
- UFLOW_CNT_WIDTH, 16, width of the saturating underflow counter.

Ports:
- clock  in  1  gearbox clock (PCS 156.25 MHz domain).
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush; empties the buffer and zeroes the counter.
- in_data  in  IN_WIDTH  scrambled block; bits [1:0] are the sync header.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  gearbox accepts in_data this cycle.
- out_en  in  1  line side takes one word this cycle.
- out_data  out  OUT_WIDTH  line word; bit 0 is first on the wire.
- out_valid  out  1  out_data holds real data (0 = underflow; out_data is zero).
- uflow_count  out  UFLOW_CNT_WIDTH  saturating count of underflow cycles.
- fill_level  out  $clog2(IN_WIDTH+OUT_WIDTH+1)  buffered bit count.

Behaviour:
- Reset (reset_n low, asynchronous) clears all state:
  - buffer = 0, count = 0, out_data = 0, out_valid = 0, uflow_count = 0.
  - in_ready reads 0 while reset is asserted.
- Storage:
  - Buffer capacity is CAP = IN_WIDTH + OUT_WIDTH bits, LSB-aligned.
  - count = number of valid bits; fill_level = count.
- Per cycle, with emit = out_en && (count >= OUT_WIDTH):
  - If emit: out_data <= buf[OUT_WIDTH-1:0], out_valid <= 1, and the buffer shifts right by OUT_WIDTH.
  - If out_en && !emit: out_valid <= 0, out_data <= 0, uflow_count increments and saturates at all-ones.
  - If !out_en: out_data and out_valid hold their previous values.
- in_ready is combinational from state and out_en: in_ready = (count - (emit ? OUT_WIDTH : 0)) <= OUT_WIDTH. The buffer therefore never overflows.
- Accept = in_valid && in_ready. The (optionally reversed) block is written at bit position count - (emit ? OUT_WIDTH : 0), i.e. after the shift.
- count_next = count - emit*OUT_WIDTH + accept*IN_WIDTH. Emit and accept in the same cycle are both applied.
- Latency: an input bit reaches out_data one cycle after the cycle in which it is emitted. The first output appears on the second out_en cycle after the first accept.
- Steady state (66/64, out_en = 1, in_valid = 1):
  - in_ready drops exactly 1 cycle in every 33.
  - 32 blocks are accepted per 33 output words.
  - out_valid stays 1 after the first emit.
- clear (synchronous, takes priority over the data path):
  - count = 0, buffer = 0, out_valid = 0, out_data = 0, uflow_count = 0.
  - in_ready = 0 during the clear cycle; no accept occurs.
- in_valid deasserted mid-stream: output drains the remaining bits, then underflows. Underflow words are never partial: a word is emitted only when count >= OUT_WIDTH.
- Reset asserted mid-operation: buffered bits are discarded immediately. After release, the first in_data is realigned to bit 0.
- MSB_FIRST = 1: in_data[IN_WIDTH-1] becomes buffer bit count (transmitted first).

Test Plan:
- Reset release, out_en = 1, in_valid = 1, incrementing 66b blocks:
  - cycle 0: out_valid = 0 and uflow_count = 1.
  - From then on out_valid = 1 continuously.
  - in_ready = 0 exactly once per 33 cycles; first low on cycle 33 after release (count = 130 -> 66).
- Block 0 = all zeros with sync header 2'b01, block 1 = all ones:
  - first out_data = 64'h0000_0000_0000_0001.
  - second out_data = {62 ones, 2'b00}; a leftover of 4 ones remains (fill_level = 4 after the next accept-free cycle).
- out_en toggling 1/0 with in_valid = 1:
  - out_data holds on out_en = 0 cycles.
  - in_valid accepts track the rate: 32 accepts per 33 out_en pulses, no overflow, fill_level <= 130 always.
- Stop in_valid after 5 blocks (330 bits):
  - exactly 5 valid words emitted (320 bits), then out_valid = 0.
  - uflow_count increments each out_en cycle; fill_level = 10.
  - Force uflow_count to all-ones: it stays at all-ones.
- Assert clear with fill_level = 68, then release:
  - fill_level = 0, out_valid = 0, uflow_count = 0, in_ready = 0 on the clear cycle.
  - The next block is emitted from bit 0.
- MSB_FIRST = 1, block = 66'h1 (only bit 0 set): the first word's bit 0 = 0; the 1 bit lands at position 65, appearing as bit 1 of the second word.
